// File: rtl/key_lut_pipe.sv
// Runtime-programmable key/data lookup table with a one-deep registered
// response stage, valid/ready handshakes and saturating hit/miss counters.
module key_lut_pipe #(
  parameter  int NR_KEY      = 4,
  parameter  int KEY_LEN     = 4,
  parameter  int DATA_LEN    = 32,
  parameter  int HAS_DEFAULT = 1,
  parameter  int CNT_LEN     = 16,
  localparam int IDX_W       = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                inv_en,
  input  logic                clr_all,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_LEN-1:0]  in_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_hit,
  output logic [IDX_W-1:0]    out_idx,
  output logic [CNT_LEN-1:0]  hit_cnt,
  output logic [CNT_LEN-1:0]  miss_cnt
);

  logic                valid_q [NR_KEY];
  logic [KEY_LEN-1:0]  key_q   [NR_KEY];
  logic [DATA_LEN-1:0] data_q  [NR_KEY];

  logic                ov_q, ov_d;
  logic [DATA_LEN-1:0] od_q, od_d;
  logic                oh_q, oh_d;
  logic [IDX_W-1:0]    oi_q, oi_d;
  logic [CNT_LEN-1:0]  hc_q, hc_d;
  logic [CNT_LEN-1:0]  mc_q, mc_d;

  logic                accept;
  logic                m_hit;
  logic [IDX_W-1:0]    m_idx;
  logic [DATA_LEN-1:0] m_data;

  assign in_ready = !ov_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    m_hit  = 1'b0;
    m_idx  = '0;
    m_data = (HAS_DEFAULT != 0) ? default_out : '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == in_key) begin
        m_hit  = 1'b1;
        m_idx  = IDX_W'(i);
        m_data = data_q[i];
      end
    end
  end

  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    oh_d = oh_q;
    oi_d = oi_q;
    if (accept) begin
      ov_d = 1'b1;
      od_d = m_data;
      oh_d = m_hit;
      oi_d = m_idx;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_comb begin
    hc_d = hc_q;
    mc_d = mc_q;
    if (clr_all) begin
      hc_d = '0;
      mc_d = '0;
    end else if (accept) begin
      if (m_hit) begin
        if (hc_q != '1) hc_d = hc_q + CNT_LEN'(1);
      end else begin
        if (mc_q != '1) mc_d = mc_q + CNT_LEN'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      od_q <= '0;
      oh_q <= 1'b0;
      oi_q <= '0;
      hc_q <= '0;
      mc_q <= '0;
    end else begin
      ov_q <= ov_d;
      od_q <= od_d;
      oh_q <= oh_d;
      oi_q <= oi_d;
      hc_q <= hc_d;
      mc_q <= mc_d;
    end
  end

  // Only in-range indices can compare equal, so oversized wr_idx is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_KEY; i++) begin
        valid_q[i] <= 1'b0;
        key_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (clr_all) begin
          valid_q[i] <= 1'b0;
        end else if (wr_idx == IDX_W'(i)) begin
          if (inv_en) begin
            valid_q[i] <= 1'b0;
          end else if (wr_en) begin
            valid_q[i] <= 1'b1;
            key_q[i]   <= wr_key;
            data_q[i]  <= wr_data;
          end
        end
      end
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_hit   = oh_q;
  assign out_idx   = oi_q;
  assign hit_cnt   = hc_q;
  assign miss_cnt  = mc_q;

endmodule

// File: tb/tb_key_lut_pipe.sv
// Bench for key_lut_pipe: a 16-bit-counter and a 2-bit-counter instance
// share one stimulus stream and are checked against a table model.
module tb_key_lut_pipe;

  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 0, inv_en = 0, clr_all = 0;
  logic [1:0]  wr_idx = 0;
  logic [3:0]  wr_key = 0, in_key = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] default_out = 32'hDEAD_BEEF;
  logic        in_valid = 0, out_ready = 1;

  logic        in_ready, out_valid, out_hit;
  logic [31:0] out_data;
  logic [1:0]  out_idx;
  logic [15:0] hit_cnt, miss_cnt;

  logic        in_ready2, out_valid2, out_hit2;
  logic [31:0] out_data2;
  logic [1:0]  out_idx2;
  logic [1:0]  hit_cnt2, miss_cnt2;

  int total = 0;
  int bad = 0;
  int acc_n = 0;
  int cons_n = 0;

  always #5 clk = ~clk;

  key_lut_pipe #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(32),
                 .HAS_DEFAULT(1), .CNT_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_key(wr_key), .wr_data(wr_data), .inv_en(inv_en),
    .clr_all(clr_all), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .default_out(default_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hit(out_hit), .out_idx(out_idx),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  key_lut_pipe #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(32),
                 .HAS_DEFAULT(1), .CNT_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_key(wr_key), .wr_data(wr_data), .inv_en(inv_en),
    .clr_all(clr_all), .in_valid(in_valid), .in_ready(in_ready2),
    .in_key(in_key), .default_out(default_out),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_hit(out_hit2), .out_idx(out_idx2),
    .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  // Table model: plain arrays plus unbounded counts saturated at compare.
  logic        m_valid [NR];
  logic [3:0]  m_key   [NR];
  logic [31:0] m_data  [NR];
  logic        m_ov;
  logic [31:0] m_od;
  logic        m_oh;
  logic [1:0]  m_oi;
  int          m_hits, m_miss;

  always @(posedge clk or negedge rst_n) begin : model
    logic        acc, hit;
    int          hi;
    logic [31:0] hd;
    if (!rst_n) begin
      m_ov = 0; m_od = 0; m_oh = 0; m_oi = 0;
      m_hits = 0; m_miss = 0;
      for (int i = 0; i < NR; i++) begin
        m_valid[i] = 0; m_key[i] = 0; m_data[i] = 0;
      end
    end else begin
      acc = in_valid && (!m_ov || out_ready);
      hit = 0; hi = 0; hd = default_out;
      for (int i = 0; i < NR; i++)
        if (!hit && m_valid[i] && m_key[i] == in_key) begin
          hit = 1; hi = i; hd = m_data[i];
        end
      if (acc) begin
        m_ov = 1; m_od = hd; m_oh = hit; m_oi = 2'(hi);
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (clr_all) begin
        m_hits = 0; m_miss = 0;
        for (int i = 0; i < NR; i++) m_valid[i] = 0;
      end else begin
        if (acc) begin
          if (hit) m_hits++;
          else m_miss++;
        end
        if (inv_en) m_valid[wr_idx] = 0;
        else if (wr_en) begin
          m_valid[wr_idx] = 1;
          m_key[wr_idx]   = wr_key;
          m_data[wr_idx]  = wr_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !m_ov || out_ready);
      chk("in_ready2", in_ready2, !m_ov || out_ready);
      chk("out_valid", out_valid, m_ov);
      chk("out_valid2", out_valid2, m_ov);
      if (m_ov) begin
        chk("out_data", out_data, m_od);
        chk("out_hit", out_hit, m_oh);
        chk("out_idx", out_idx, m_oi);
        chk("out_data2", out_data2, m_od);
        chk("out_hit2", out_hit2, m_oh);
        chk("out_idx2", out_idx2, m_oi);
      end
      chk("hit_cnt", hit_cnt, sat(m_hits, 16));
      chk("miss_cnt", miss_cnt, sat(m_miss, 16));
      chk("hit_cnt2", hit_cnt2, sat(m_hits, 2));
      chk("miss_cnt2", miss_cnt2, sat(m_miss, 2));
      if (in_valid && in_ready) acc_n++;
      if (out_valid && out_ready) cons_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] i, input logic [3:0] k,
                    input logic [31:0] d);
    wr_en = 1; wr_idx = i; wr_key = k; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic lookup(input logic [3:0] k);
    in_valid = 1; in_key = k;
    tick();
    in_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    repeat (2) tick();
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst hit_cnt", hit_cnt, 0);
    chk("rst miss_cnt", miss_cnt, 0);
    rst_n = 1;
    tick();

    lookup(4'h3);
    chk("miss valid", out_valid, 1);
    chk("miss hit", out_hit, 0);
    chk("miss data", out_data, 32'hDEAD_BEEF);
    chk("miss idx", out_idx, 0);
    chk("miss cnt", miss_cnt, 1);
    tick();

    wr(2, 4'h5, 32'h1234);
    lookup(4'h5);
    chk("hit hit", out_hit, 1);
    chk("hit idx", out_idx, 2);
    chk("hit data", out_data, 32'h1234);
    chk("hit cnt", hit_cnt, 1);

    wr(1, 4'hA, 32'd11);
    wr(3, 4'hA, 32'd33);
    lookup(4'hA);
    chk("dup idx", out_idx, 1);
    chk("dup data", out_data, 32'd11);
    inv_en = 1; wr_idx = 1;
    tick();
    inv_en = 0;
    lookup(4'hA);
    chk("inv idx", out_idx, 3);
    chk("inv data", out_data, 32'd33);

    wr_en = 1; wr_idx = 0; wr_key = 4'h7; wr_data = 32'h77;
    in_valid = 1; in_key = 4'h7;
    tick();
    wr_en = 0; in_valid = 0;
    chk("rbw miss", out_hit, 0);
    lookup(4'h7);
    chk("rbw hit", out_hit, 1);
    chk("rbw data", out_data, 32'h77);
    tick();

    out_ready = 0; in_valid = 1; in_key = 4'h5;
    tick();
    chk("bp in_ready", in_ready, 0);
    in_key = 4'hA;
    tick();
    chk("bp hold1", out_data, 32'h1234);
    tick();
    chk("bp hold2", out_data, 32'h1234);
    chk("bp hold2 v", out_valid, 1);
    out_ready = 1;
    tick();
    chk("bp second", out_data, 32'd33);
    in_key = 4'h7;
    tick();
    chk("bp third", out_data, 32'h77);
    in_valid = 0;
    tick();
    chk("bp drained", out_valid, 0);
    chk("bp accepts", acc_n, 9);
    chk("bp consumed", cons_n, 9);
    chk("bp hits", hit_cnt, 7);
    chk("bp misses", miss_cnt, 2);

    for (int n = 0; n < 5; n++) lookup(4'hF);
    chk("sat miss16", miss_cnt, 7);
    chk("sat miss2", miss_cnt2, 3);
    chk("sat hit2", hit_cnt2, 3);

    clr_all = 1; in_valid = 1; in_key = 4'h5;
    tick();
    clr_all = 0; in_valid = 0;
    chk("clr resp", out_hit, 1);
    chk("clr data", out_data, 32'h1234);
    chk("clr hit2", hit_cnt2, 0);
    chk("clr miss2", miss_cnt2, 0);
    chk("clr hit16", hit_cnt, 0);
    lookup(4'h5);
    chk("clr empty", out_hit, 0);
    chk("clr miss after", miss_cnt2, 1);

    wr_en = 1; inv_en = 1; wr_idx = 0; wr_key = 4'h9; wr_data = 32'h99;
    tick();
    wr_en = 0; inv_en = 0;
    lookup(4'h9);
    chk("inv beats wr", out_hit, 0);

    wr(0, 4'h2, 32'h22);
    out_ready = 0;
    lookup(4'h2);
    chk("pre-rst pend", out_valid, 1);
    rst_n = 0;
    #1;
    chk("rst drop", out_valid, 0);
    tick();
    rst_n = 1;
    out_ready = 1;
    tick();
    lookup(4'h2);
    chk("rst table", out_hit, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_lut_pipe.md
Name: key_lut_pipe

Overview:
- Runtime-programmable successor to the fixed key/data lookup mux: NR_KEY entries of {valid, key, data}, written at run time instead of wired as a constant LUT.
- Lookups enter through a valid/ready handshake and return through a registered, backpressurable response carrying data, hit flag and hit index.
- Saturating hit and miss counters are included.
- Used in NPC for decode/CSR-style lookups where table contents change after reset.

Parameters:
- NR_KEY, 4: number of table entries (≥1).
- KEY_LEN, 4: key width.
- DATA_LEN, 32: data width.
- HAS_DEFAULT, 1: 1 = miss returns default_out; 0 = miss returns all-zero data.
- CNT_LEN, 16: width of the hit/miss statistics counters.
- IDX_W, derived: max(1, clog2(NR_KEY)). Not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write entry wr_idx this cycle.
- wr_idx  in  IDX_W  target entry.
- wr_key  in  KEY_LEN  key to store.
- wr_data  in  DATA_LEN  data to store.
- inv_en  in  1  invalidate entry wr_idx.
- clr_all  in  1  invalidate all entries and zero the counters.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  lookup request accepted when in_valid && in_ready.
- in_key  in  KEY_LEN  lookup key.
- default_out  in  DATA_LEN  miss value, sampled at accept.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_LEN  looked-up data.
- out_hit  out  1  1 = key matched a valid entry.
- out_idx  out  IDX_W  index of the matching entry; 0 on miss.
- hit_cnt  out  CNT_LEN  accepted lookups that hit, saturating.
- miss_cnt  out  CNT_LEN  accepted lookups that missed, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0): all entry valid bits 0; entry key/data registers 0; out_valid, out_data, out_hit, out_idx, hit_cnt, miss_cnt all 0. in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, full-throughput, no skid buffer).
  - On accept, the match is computed combinationally against the table as it stands before this edge; the result is registered.
  - out_valid=1 from the next cycle. Latency is exactly 1 cycle.
  - Response fields stay stable while out_valid && !out_ready.
  - out_valid clears on (out_valid && out_ready && !accept).
  - Back-to-back accepts with out_ready=1 give one response per cycle.
- Match rule:
  - An entry hits when valid[i] && key[i]==in_key.
  - Multiple hits: lowest index wins.
  - Hit: out_data=data[i], out_idx=i, out_hit=1.
  - Miss: out_data = HAS_DEFAULT ? default_out : 0; out_idx=0; out_hit=0.
- Table update priority, highest first:
  - clr_all: all valid bits 0. Key/data contents are don't-care.
  - inv_en: valid[wr_idx]=0. Wins over wr_en to the same index.
  - wr_en: key/data[wr_idx] written, valid[wr_idx]=1.
  - wr_idx ≥ NR_KEY: write or invalidate ignored.
- Read-before-write: a lookup accepted in the same cycle as a write, invalidate or clear sees the old table. The change is visible to lookups accepted from the next cycle.
- Counters:
  - On each accept, hit_cnt or miss_cnt increments by 1, saturating at all-ones.
  - clr_all zeroes both counters. A lookup accepted in the same cycle as clr_all is not counted, but its response is still produced from the old table.
- Reset mid-operation: a pending response is discarded (out_valid=0 immediately) and the table is emptied.

Test Plan:
- Reset, then lookup in_key=4'h3 with default_out=32'hDEAD_BEEF → 1 cycle later out_valid=1, out_hit=0, out_data=32'hDEADBEEF, out_idx=0, miss_cnt=1.
- Write idx2 {key 4'h5, data 32'h1234}; next cycle look up 4'h5 → out_hit=1, out_idx=2, out_data=32'h1234, hit_cnt=1.
- Duplicate keys: idx1 and idx3 both key 4'hA (data 11/33) → lookup 4'hA returns out_idx=1, out_data=11. Then invalidate idx1 → next lookup returns idx3 / 33.
- Same-cycle write idx0 {4'h7, 32'h77} with lookup of 4'h7 → miss (old table). Repeat the lookup one cycle later → hit, data 32'h77.
- Backpressure: three back-to-back requests, out_ready=0 for 2 cycles → in_ready=0 after the first accept; first response is held stable; no responses lost or duplicated once out_ready=1; counters total 3.
- Counter saturation with CNT_LEN=2: 5 misses → miss_cnt=3. Then clr_all with a simultaneous lookup → counters 0, valid bits 0, and that response is still returned.
